// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LogicNets neuron truth table: a valid/ready config writer fills the table beat
// by beat, and a registered one-cycle lookup port serves M0 -> M1 once the table is loaded.
module lut_neuron_loader #(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned OUT_W        = 1,
    parameter int unsigned BEAT_ENTRIES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [OUT_W*BEAT_ENTRIES-1:0] cfg_data,
    input  logic                          cfg_last,
    output logic                          cfg_err,
    output logic                          loaded,
    input  logic [ADDR_W-1:0]             M0,
    input  logic                          M0_valid,
    output logic [OUT_W-1:0]              M1,
    output logic                          M1_valid
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NBEATS = DEPTH / BEAT_ENTRIES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

    state_e            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [OUT_W-1:0]  table_q [DEPTH];
    logic              hs;

    // cfg_start wins over a same-cycle beat, so that beat is dropped rather than written
    assign hs = cfg_valid && cfg_ready && !cfg_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        state_q   <= StLoad;
                        beat_q    <= '0;
                        cfg_err   <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    if (cfg_start) begin
                        beat_q  <= '0;
                        cfg_err <= 1'b0;
                    end else if (hs) begin
                        if (beat_q == LAST_BEAT) begin
                            // every entry is written, so the table is usable even without cfg_last
                            state_q   <= StReady;
                            cfg_ready <= 1'b0;
                            loaded    <= 1'b1;
                            cfg_err   <= !cfg_last;
                        end else if (cfg_last) begin
                            state_q   <= StIdle;
                            cfg_ready <= 1'b0;
                            cfg_err   <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StReady: begin
                    if (cfg_start) begin
                        state_q   <= StLoad;
                        beat_q    <= '0;
                        cfg_err   <= 1'b0;
                        cfg_ready <= 1'b1;
                        loaded    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cfg_ready <= 1'b0;
                    loaded    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (hs) begin
            for (int k = 0; k < BEAT_ENTRIES; k++) begin
                table_q[ADDR_W'(beat_q * BEAT_ENTRIES + k)] <= cfg_data[k*OUT_W +: OUT_W];
            end
        end
    end

    // Asynchronous table read feeding the output register; M1 holds when no lookup fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M1       <= '0;
            M1_valid <= 1'b0;
        end else begin
            M1_valid <= loaded && M0_valid;
            if (loaded && M0_valid) begin
                M1 <= table_q[M0];
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader: hand vectors, framing corner cases and random
// loads/lookups checked against a plain array model of the truth table.
module tb_lut_neuron_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_last = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       loaded;
    logic [5:0] M0 = '0;
    logic       M0_valid = 1'b0;
    logic [0:0] M1;
    logic       M1_valid;

    lut_neuron_loader #(
        .ADDR_W      (6),
        .OUT_W       (1),
        .BEAT_ENTRIES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
        .cfg_err  (cfg_err),
        .loaded   (loaded),
        .M0       (M0),
        .M0_valid (M0_valid),
        .M1       (M1),
        .M1_valid (M1_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int exp_m1;
    } vec_t;

    int         passed = 0;
    int         total = 0;
    bit         model [64];
    logic [7:0] beat_data [8];
    vec_t       vecs [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // Sends beats first..first+n-1 from beat_data; cfg_last on beat last_idx (-1: never)
    task automatic send_beats(input int first, input int n, input int last_idx, input bit gaps);
        for (int b = first; b < first + n; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b0;
                step();
            end
            cfg_valid = 1'b1;
            cfg_data  = beat_data[b];
            cfg_last  = (b == last_idx);
            check("cfg_ready_during_load", int'(cfg_ready), 1);
            step();
            for (int k = 0; k < 8; k++) model[b*8+k] = beat_data[b][k];
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic lookup_chk(input int addr);
        M0       = 6'(addr);
        M0_valid = 1'b1;
        step();
        check("lookup_valid", int'(M1_valid), 1);
        check("lookup_data", int'(M1), int'(model[addr]));
        M0_valid = 1'b0;
    endtask

    task automatic sweep_all(input bit use_const, input int const_val);
        M0_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            M0 = 6'(i);
            step();
            check("sweep_valid", int'(M1_valid), 1);
            check("sweep_data", int'(M1), use_const ? const_val : int'(model[i]));
        end
        M0_valid = 1'b0;
        step();
        check("sweep_valid_drop", int'(M1_valid), 0);
    endtask

    task automatic random_lookups(input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            bit v;
            a = int'($urandom_range(0, 63));
            v = 1'($urandom_range(0, 3) != 0);
            M0 = 6'(a);
            M0_valid = v;
            step();
            check("rand_valid", int'(M1_valid), int'(v));
            if (v) check("rand_data", int'(M1), int'(model[a]));
        end
        M0_valid = 1'b0;
    endtask

    task automatic randomize_beats();
        for (int b = 0; b < 8; b++) beat_data[b] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 1'b0;
        // Entries 44,45 (beat 5) and 60,61 (beat 7) are the set bits of 8'h30
        vecs[0] = '{45, 1};
        vecs[1] = '{44, 1};
        vecs[2] = '{61, 1};
        vecs[3] = '{63, 0};
        vecs[4] = '{60, 1};
        vecs[5] = '{43, 0};
        vecs[6] = '{0, 0};
        vecs[7] = '{46, 0};

        step();
        step();
        check("rst_cfg_ready", int'(cfg_ready), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_loaded", int'(loaded), 0);
        check("rst_M1", int'(M1), 0);
        check("rst_M1_valid", int'(M1_valid), 0);
        rst = 1'b0;
        step();

        // Lookups are ignored before any load
        M0 = 6'd5;
        M0_valid = 1'b1;
        step();
        check("idle_lookup_valid", int'(M1_valid), 0);
        M0_valid = 1'b0;

        // Hand-written table load
        for (int b = 0; b < 8; b++) beat_data[b] = 8'h00;
        beat_data[5] = 8'h30;
        beat_data[7] = 8'h30;
        start_pulse();
        send_beats(0, 8, 7, 1'b0);
        check("load_loaded", int'(loaded), 1);
        check("load_err", int'(cfg_err), 0);
        check("load_ready_low", int'(cfg_ready), 0);
        for (int i = 0; i < 8; i++) begin
            M0 = 6'(vecs[i].addr);
            M0_valid = 1'b1;
            step();
            check("vec_valid", int'(M1_valid), 1);
            check("vec_data", int'(M1), vecs[i].exp_m1);
        end
        M0_valid = 1'b0;
        sweep_all(1'b0, 0);

        // cfg_start in READY: same-cycle lookup still served from the old table
        cfg_start = 1'b1;
        M0 = 6'd45;
        M0_valid = 1'b1;
        step();
        cfg_start = 1'b0;
        M0_valid = 1'b0;
        check("start_lookup_valid", int'(M1_valid), 1);
        check("start_lookup_data", int'(M1), 1);
        check("start_drops_loaded", int'(loaded), 0);
        check("start_ready_high", int'(cfg_ready), 1);

        // Early cfg_last on beat 3
        randomize_beats();
        send_beats(0, 4, 3, 1'b0);
        check("early_last_err", int'(cfg_err), 1);
        check("early_last_loaded", int'(loaded), 0);
        check("early_last_ready", int'(cfg_ready), 0);
        M0 = 6'd7;
        M0_valid = 1'b1;
        step();
        check("early_last_no_valid", int'(M1_valid), 0);
        check("early_last_M1_held", int'(M1), 1);
        M0_valid = 1'b0;
        step();
        check("early_last_err_sticky", int'(cfg_err), 1);

        // Missing cfg_last on beat 7
        start_pulse();
        check("start_clears_err", int'(cfg_err), 0);
        randomize_beats();
        send_beats(0, 8, -1, 1'b1);
        check("no_last_err", int'(cfg_err), 1);
        check("no_last_loaded", int'(loaded), 1);
        random_lookups(24);

        // Restart mid-load at beat 4, then a full all-ones load
        start_pulse();
        check("restart_err_cleared", int'(cfg_err), 0);
        randomize_beats();
        send_beats(0, 4, -1, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_not_loaded", int'(loaded), 0);
        for (int b = 0; b < 8; b++) beat_data[b] = 8'hFF;
        send_beats(0, 8, 7, 1'b0);
        check("ones_err", int'(cfg_err), 0);
        check("ones_loaded", int'(loaded), 1);
        sweep_all(1'b1, 1);

        // Asynchronous reset in the middle of beat 2
        start_pulse();
        randomize_beats();
        send_beats(0, 2, -1, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = beat_data[2];
        #3;
        rst = 1'b1;
        #1;
        check("arst_loaded", int'(loaded), 0);
        check("arst_ready", int'(cfg_ready), 0);
        check("arst_err", int'(cfg_err), 0);
        check("arst_M1", int'(M1), 0);
        check("arst_M1_valid", int'(M1_valid), 0);
        cfg_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 1'b0;
        step();
        check("arst_idle_ready", int'(cfg_ready), 0);

        // Fresh random loads after reset
        for (int r = 0; r < 4; r++) begin
            start_pulse();
            randomize_beats();
            send_beats(0, 8, 7, 1'b1);
            check("rand_load_loaded", int'(loaded), 1);
            check("rand_load_err", int'(cfg_err), 0);
            random_lookups(40);
            if (r == 0) sweep_all(1'b0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
